// File: rtl/count_enable_gen_if.sv
// Control/status bundle between system control and count_enable_gen.
// The master side drives run requests; the slave side returns the pulse train and status.
interface count_enable_gen_if #(
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned LEN_W      = 4
);
    logic                  start;
    logic                  stop;
    logic                  step;
    logic [PRESCALE_W-1:0] prescale;
    logic [LEN_W-1:0]      run_len;
    logic                  count_enable;
    logic                  busy;
    logic                  done;
    logic [LEN_W-1:0]      pulses_left;

    modport master (
        output start, stop, step, prescale, run_len,
        input  count_enable, busy, done, pulses_left
    );

    modport slave (
        input  start, stop, step, prescale, run_len,
        output count_enable, busy, done, pulses_left
    );
endinterface

// File: rtl/count_enable_gen.sv
// Pulse-rate generator feeding count_enable of the 4-bit JK counter.
// Supports free-running or N-pulse runs, stop/abort and single-step from idle.
module count_enable_gen #(
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned LEN_W      = 4
) (
    input  logic               clk,
    input  logic               clear,
    count_enable_gen_if.slave  bus
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] prescale_lat;
    logic [LEN_W-1:0]      remain;
    logic                  free;

    logic                  count_enable_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LEN_W-1:0]      pulses_left_q;

    assign bus.count_enable = count_enable_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pulses_left  = pulses_left_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state          <= StIdle;
            pcnt           <= '0;
            prescale_lat   <= '0;
            remain         <= '0;
            free           <= 1'b0;
            count_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pulses_left_q  <= '0;
        end else begin
            count_enable_q <= 1'b0;
            done_q         <= 1'b0;
            unique case (state)
                StIdle: begin
                    busy_q        <= 1'b0;
                    pulses_left_q <= '0;
                    // stop outranks start and step even while idle
                    if (bus.stop) begin
                        state <= StIdle;
                    end else if (bus.start) begin
                        state         <= StRun;
                        pcnt          <= bus.prescale;
                        prescale_lat  <= bus.prescale;
                        remain        <= bus.run_len;
                        free          <= (bus.run_len == '0);
                        busy_q        <= 1'b1;
                        pulses_left_q <= bus.run_len;
                    end else if (bus.step) begin
                        count_enable_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state         <= StIdle;
                        remain        <= '0;
                        busy_q        <= 1'b0;
                        pulses_left_q <= '0;
                    end else if (pcnt != '0) begin
                        pcnt <= pcnt - 1'b1;
                    end else begin
                        pcnt           <= prescale_lat;
                        count_enable_q <= 1'b1;
                        if (!free) begin
                            remain        <= remain - 1'b1;
                            pulses_left_q <= remain - 1'b1;
                            // busy is held through the final pulse cycle, dropped in idle
                            if (remain == LEN_W'(1)) begin
                                state  <= StIdle;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// Self-checking bench for count_enable_gen: directed scenarios plus random traffic,
// compared every cycle against a schedule-based reference model.
module tb_count_enable_gen;

    localparam int unsigned PW = 8;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic clear;

    count_enable_gen_if #(.PRESCALE_W(PW), .LEN_W(LW)) bus ();

    count_enable_gen #(.PRESCALE_W(PW), .LEN_W(LW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a run is a schedule of pulses at edges s+1+P+i*(P+1).
    int m_edge   = 0;
    bit m_run    = 0;
    int m_s      = 0;
    int m_p      = 0;
    int m_n      = 0;
    int m_issued = 0;
    bit m_ce     = 0;
    bit m_busy   = 0;
    bit m_done   = 0;
    int m_pl     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, m_edge, got, exp);
    endtask

    task automatic model_step();
        int d;
        m_edge++;
        m_ce   = 0;
        m_done = 0;
        if (clear) begin
            m_run  = 0;
            m_busy = 0;
            m_pl   = 0;
        end else if (m_run) begin
            if (bus.stop) begin
                m_run  = 0;
                m_busy = 0;
                m_pl   = 0;
            end else begin
                m_busy = 1;
                d = m_edge - m_s - 1 - m_p;
                if (d >= 0 && (d % (m_p + 1)) == 0) begin
                    m_ce = 1;
                    m_issued++;
                    if (m_n != 0 && m_issued == m_n) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
                m_pl = (m_n != 0) ? (m_n - m_issued) : 0;
            end
        end else begin
            m_busy = 0;
            m_pl   = 0;
            if (bus.stop) begin
                m_run = 0;
            end else if (bus.start) begin
                m_run    = 1;
                m_s      = m_edge;
                m_p      = int'(bus.prescale);
                m_n      = int'(bus.run_len);
                m_issued = 0;
                m_busy   = 1;
                m_pl     = m_n;
            end else if (bus.step) begin
                m_ce = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("count_enable", 32'(bus.count_enable), 32'(m_ce));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("pulses_left", 32'(bus.pulses_left), 32'(m_pl));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_run(input int p, input int n);
        bus.prescale = PW'(p);
        bus.run_len  = LW'(n);
        bus.start    = 1'b1;
        cycle();
        bus.start    = 1'b0;
    endtask

    int ce_seen;

    initial begin
        clear        = 1'b1;
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        bus.step     = 1'b0;
        bus.prescale = '0;
        bus.run_len  = '0;

        // Reset held with start asserted
        cycles(2);
        clear     = 1'b0;
        bus.start = 1'b0;
        cycles(3);

        // Finite run P=2, N=4
        start_run(2, 4);
        ce_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            ce_seen += int'(bus.count_enable);
        end
        check("finite_pulse_total", 32'(ce_seen), 32'd4);

        // Free run P=0, N=0, then stop
        start_run(0, 0);
        cycles(20);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        cycles(3);

        // Stop on the edge where the second pulse would be issued
        start_run(3, 8);
        cycles(7);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        cycles(6);

        // Three steps from idle, five cycles apart
        ce_seen = 0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1;
            cycle();
            ce_seen += int'(bus.count_enable);
            bus.step = 1'b0;
            for (int i = 0; i < 4; i++) begin
                cycle();
                ce_seen += int'(bus.count_enable);
            end
        end
        check("step_pulse_total", 32'(ce_seen), 32'd3);

        // Steps during a run add nothing
        start_run(5, 3);
        bus.step = 1'b1;
        cycles(20);
        bus.step = 1'b0;
        cycles(3);

        // Reconfigure mid-run, then clear after the third pulse
        start_run(1, 6);
        bus.prescale = PW'(7);
        bus.run_len  = LW'(2);
        cycles(6);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycles(10);

        // Back-to-back runs with start held high
        bus.prescale = PW'(1);
        bus.run_len  = LW'(2);
        bus.start    = 1'b1;
        cycles(14);
        bus.start    = 1'b0;
        cycles(5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            clear        = ($urandom_range(199) == 0);
            bus.stop     = ($urandom_range(29) == 0);
            bus.start    = ($urandom_range(7) == 0);
            bus.step     = ($urandom_range(5) == 0);
            bus.prescale = PW'($urandom_range(5));
            bus.run_len  = LW'($urandom_range(5));
            cycle();
        end
        clear     = 1'b0;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_enable_gen.md
# count_enable_gen

Upstream control stage for the 4-bit JK synchronous counter. It produces the counter's `count_enable` input as single-cycle pulses at a programmable rate. It also supports a programmable run length (free-running or N pulses), stop/abort, and single-step from idle. Reporting back to system control is through `busy`, `done` and a remaining-pulse count.

## Interface
- `PRESCALE_W`, 8: width of the prescale value; pulse period is prescale+1 cycles.
- `LEN_W`, 4: width of the run length and remaining-pulse count.
- `clk` input 1: single clock; all state changes on its rising edge.
- `clear` input 1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `start` input 1: begin a run when idle; level-sampled every edge.
- `stop` input 1: abort the current run.
- `step` input 1: request one pulse when idle.
- `prescale` input PRESCALE_W: pulse spacing minus one; sampled only when a start is accepted.
- `run_len` input LEN_W: number of pulses per run, 0 = free-running; sampled only when a start is accepted.
- `count_enable` output 1: registered pulse to the counter, high for exactly one cycle per count.
- `busy` output 1: registered, high while a run is active.
- `done` output 1: registered, one-cycle pulse on completion of a finite run.
- `pulses_left` output LEN_W: pulses still to be issued in a finite run; 0 when idle or free-running.

## Operation
- States: IDLE, RUN. Internal registers: `pcnt` (PRESCALE_W), `remain` (LEN_W), `free` (1).
- Input priority on each edge: `clear` > `stop` > `start` > `step`.
- `clear`: state IDLE; `pcnt`, `remain`, `free` are 0; `count_enable`, `busy`, `done`, `pulses_left` are all 0 at the next edge.
- IDLE + `start`:
  - state goes to RUN; `pcnt` loads `prescale`; `remain` loads `run_len`.
  - `free` is set to (`run_len`==0).
  - `busy` is 1 from the next cycle.
- IDLE + `step` (no `start`): `count_enable` is 1 for the next cycle only; state stays IDLE; `busy` and `done` stay 0.
- RUN, each edge without `stop`:
  - If `pcnt`!=0: `pcnt` decrements.
  - If `pcnt`==0: `pcnt` reloads the latched prescale, `count_enable` is 1 for the next cycle, and `remain` decrements unless `free`.
  - If `pcnt`==0 and `remain`==1 and not `free`: this is the last pulse. State goes to IDLE and `done` is 1 in the same cycle as the last `count_enable`.
- RUN + `stop`:
  - State goes to IDLE immediately; no pulse is issued on that edge, even if `pcnt`==0.
  - `done` stays 0; `pulses_left` clears to 0.
- RUN + `start` or `step`: ignored; no restart and no extra pulse.
- `prescale` and `run_len` are latched at start. Changes during RUN have no effect.
- `pulses_left` equals `remain` in RUN when not `free`; otherwise 0.
- Counter wrap is the downstream counter's concern. This block counts pulses, not counter values.

## Timing
- Start latency: `start` sampled at edge k. The first `count_enable` is high during the cycle after edge k+1+P, where P = latched prescale.
- Pulse period is P+1 cycles. With P=0, `count_enable` is high continuously, one count per cycle.
- `count_enable` is never high two cycles in a row unless P=0. It is never wider than one cycle per count.
- `busy` rises the cycle after the accepted start. It falls the cycle after the final `count_enable` cycle for a finite run, or the cycle after a stop.
- `done` is high for exactly one cycle, coincident with the last `count_enable`. It is never asserted on stop or clear.
- Step latency: `step` sampled at edge k gives `count_enable` high in the cycle after edge k.
- `clear` mid-run: all outputs are 0 from the next cycle; no `done`.
- Back-to-back runs: `start` held high through completion restarts at the edge after the IDLE transition. There are no lost or extra pulses.

## Test plan
- Reset: assert `clear` for 2 cycles with `start`=1 → `count_enable`, `busy`, `done`, `pulses_left` are all 0, and no pulse follows until `clear` drops.
- Finite run: P=2, `run_len`=4, start pulse → exactly 4 `count_enable` pulses spaced 3 cycles apart.
  - First pulse is 4 cycles after the start edge.
  - `done` is coincident with the 4th pulse.
  - `pulses_left` reads 4,3,2,1,0.
  - `busy` falls 1 cycle after the 4th pulse.
- Free-run with counter attached: P=0, `run_len`=0, start → counter increments every cycle and wraps 1111→0000. `done` is never asserted and `pulses_left` stays 0.
- Stop on pulse edge: P=3, `run_len`=8, assert `stop` on the edge where `pcnt`==0 → no pulse on that edge and `done`=0. `busy` drops the next cycle; the counter holds its value.
- Step: in IDLE, 3 single-cycle `step` pulses 5 cycles apart → exactly 3 one-cycle `count_enable` pulses, counter goes 0→3. `step` during RUN adds no pulse.
- Mid-run reconfiguration and clear: start with P=1, `run_len`=6, change `prescale` to 7 mid-run → spacing stays 2 cycles. Assert `clear` after the 3rd pulse → no further pulses and no `done`.
